// File: rtl/traffic_pkg.sv
// Shared light codes, phase and FSM state types, and the light-pair decoder
// used by the traffic phase timer.
package traffic_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_GREEN  = 2'b11;

    typedef enum logic [1:0] {
        PH_V_GRN,
        PH_YEL,
        PH_H_GRN,
        PH_BAD
    } phase_t;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_DWELL,
        ST_PULSE,
        ST_WAIT_CHG,
        ST_HALT
    } state_t;

    // Any pair the controller should never show maps to PH_BAD.
    function automatic phase_t decode_phase(input logic [1:0] hLight,
                                            input logic [1:0] vLight);
        if (hLight == LIGHT_RED && vLight == LIGHT_GREEN) begin
            return PH_V_GRN;
        end
        if (hLight == LIGHT_YELLOW && vLight == LIGHT_YELLOW) begin
            return PH_YEL;
        end
        if (hLight == LIGHT_GREEN && vLight == LIGHT_RED) begin
            return PH_H_GRN;
        end
        return PH_BAD;
    endfunction

endpackage

// File: rtl/traffic_dwell_counter.sv
// Saturating dwell counter with synchronous clear; counts cycles spent in the
// currently observed light phase.
module traffic_dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// Pacing stage for the traffic light controller: watches the lights, times each
// phase, and pulses x1 low to let the controller step; faults on bad feedback.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN   = 8,
    parameter int GREEN_MAX   = 32,
    parameter int YELLOW_TIME = 3,
    parameter int ACK_TIMEOUT = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       horizontal_light,
    input  logic [1:0]       vertical_light,
    input  logic             h_sensor,
    input  logic             v_sensor,
    input  logic             ped_req,
    output logic             x1,
    output logic             ped_ack,
    output logic             fault,
    output logic [CNT_W-1:0] dwell_cnt
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic              pedPending_q, pedPending_d;
    logic              fault_q, fault_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;

    phase_t            obsPhase;
    logic              isGreen;
    logic              crossDemand;
    logic [CNT_W-1:0]  threshold;
    logic              cntClear;
    logic              cntInc;

    assign obsPhase    = decode_phase(horizontal_light, vertical_light);
    assign isGreen     = (phase_q == PH_H_GRN) || (phase_q == PH_V_GRN);
    assign crossDemand = pedPending_q |
                         ((phase_q == PH_H_GRN) ? v_sensor : h_sensor);

    // Demand is looked at every cycle, so late demand after GREEN_MIN cuts green at once.
    always_comb begin
        threshold = CNT_W'(GREEN_MAX);
        if (phase_q == PH_YEL) begin
            threshold = CNT_W'(YELLOW_TIME);
        end else if (crossDemand) begin
            threshold = CNT_W'(GREEN_MIN);
        end
    end

    traffic_dwell_counter #(
        .CNT_W(CNT_W)
    ) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .clear_i(cntClear),
        .inc_i  (cntInc),
        .count_o(dwell_cnt)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        fault_d   = fault_q;
        waitCnt_d = waitCnt_q;
        cntClear  = 1'b0;
        cntInc    = 1'b0;
        x1        = 1'b1;
        ped_ack   = 1'b0;

        case (state_q)
            ST_SYNC: begin
                cntClear = 1'b1;
                phase_d  = obsPhase;
                state_d  = (obsPhase == PH_BAD) ? ST_HALT : ST_DWELL;
            end
            ST_DWELL: begin
                if (dwell_cnt >= threshold) begin
                    state_d = ST_PULSE;
                end else begin
                    cntInc = 1'b1;
                end
            end
            ST_PULSE: begin
                x1        = 1'b0;
                ped_ack   = isGreen && pedPending_q;
                waitCnt_d = '0;
                state_d   = ST_WAIT_CHG;
            end
            ST_WAIT_CHG: begin
                if (obsPhase != phase_q) begin
                    phase_d  = obsPhase;
                    cntClear = 1'b1;
                    state_d  = ST_DWELL;
                end else if (waitCnt_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        if ((state_q != ST_SYNC) && (obsPhase == PH_BAD)) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
        end
    end

    // A request landing in the servicing cycle wins, so it carries to the next green.
    assign pedPending_d = ped_req | (pedPending_q & ~ped_ack);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_SYNC;
            phase_q      <= PH_BAD;
            pedPending_q <= 1'b0;
            fault_q      <= 1'b0;
            waitCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            pedPending_q <= pedPending_d;
            fault_q      <= fault_d;
            waitCnt_q    <= waitCnt_d;
        end
    end

    assign fault = fault_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench: the phase timer paces a small behavioural model of the
// traffic light controller, whose active-high reset is tied to ~reset.
module tb_traffic_phase_timer;

    logic       clk;
    logic       reset;
    logic [1:0] horizontal_light;
    logic [1:0] vertical_light;
    logic       h_sensor;
    logic       v_sensor;
    logic       ped_req;
    logic       x1;
    logic       ped_ack;
    logic       fault;
    logic [7:0] dwell_cnt;

    int compared;
    int mismatched;

    // Controller model: HG -> Y -> VG -> Y, one step per x1-low edge.
    logic [1:0] ctrlSt;
    logic       freeze;
    logic       forceEn;
    logic [1:0] forceH;
    logic [1:0] forceV;
    logic [1:0] hModel;
    logic [1:0] vModel;

    traffic_phase_timer #(
        .GREEN_MIN  (8),
        .GREEN_MAX  (32),
        .YELLOW_TIME(3),
        .ACK_TIMEOUT(4),
        .CNT_W      (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .horizontal_light(horizontal_light),
        .vertical_light  (vertical_light),
        .h_sensor        (h_sensor),
        .v_sensor        (v_sensor),
        .ped_req         (ped_req),
        .x1              (x1),
        .ped_ack         (ped_ack),
        .fault           (fault),
        .dwell_cnt       (dwell_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (~reset) begin
            ctrlSt <= 2'd0;
        end else if (!freeze && !x1) begin
            ctrlSt <= ctrlSt + 2'd1;
        end
    end

    always_comb begin
        hModel = 2'b10;
        vModel = 2'b10;
        case (ctrlSt)
            2'd0: begin hModel = 2'b11; vModel = 2'b00; end
            2'd2: begin hModel = 2'b00; vModel = 2'b11; end
            default: begin hModel = 2'b10; vModel = 2'b10; end
        endcase
    end

    assign horizontal_light = forceEn ? forceH : hModel;
    assign vertical_light   = forceEn ? forceV : vModel;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic waitPulse(input int maxCycles, output int ticks, output bit found);
        ticks = 0;
        found = 1'b0;
        while (!found && ticks < maxCycles) begin
            tick();
            ticks++;
            if (x1 === 1'b0) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (x1 !== 1'b1 || fault !== 1'b0 || dwell_cnt !== 8'd0 || ped_ack !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_cycle%0d: x1=%b fault=%b dwell=%0d ack=%b, want 1 0 0 0",
                         i, x1, fault, dwell_cnt, ped_ack);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_full_cycle;
        int  expCnt[4];
        int  expTicks[4];
        int  ticks;
        bit  found;
        expCnt   = '{32, 3, 32, 3};
        expTicks = '{34, 6, 35, 6};
        doReset();
        for (int p = 0; p < 4; p++) begin
            waitPulse(60, ticks, found);
            compared++;
            if (!found || dwell_cnt !== 8'(expCnt[p]) || ticks != expTicks[p] || ped_ack !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL full_cycle_pulse%0d: found=%b dwell=%0d ticks=%0d ack=%b, want dwell=%0d ticks=%0d ack=0",
                         p, found, dwell_cnt, ticks, ped_ack, expCnt[p], expTicks[p]);
            end
        end
        tick();
        tick();
        compared++;
        if (fault !== 1'b0 || horizontal_light !== 2'b11 || dwell_cnt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL full_cycle_wrap: fault=%b hLight=%b dwell=%0d, want 0 11 0",
                     fault, horizontal_light, dwell_cnt);
        end
    endtask

    task automatic test_sensor;
        int ticks;
        bit found;
        v_sensor = 1'b1;
        doReset();
        waitPulse(60, ticks, found);
        compared++;
        if (!found || dwell_cnt !== 8'd8 || ticks != 10) begin
            mismatched++;
            $display("[TB] FAIL sensor_early: found=%b dwell=%0d ticks=%0d, want dwell=8 ticks=10",
                     found, dwell_cnt, ticks);
        end

        v_sensor = 1'b0;
        doReset();
        ticks = 0;
        while (dwell_cnt !== 8'd20 && ticks < 40) begin
            tick();
            ticks++;
        end
        compared++;
        if (dwell_cnt !== 8'd20 || x1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sensor_late_reach20: dwell=%0d x1=%b, want 20 1", dwell_cnt, x1);
        end
        v_sensor = 1'b1;
        tick();
        compared++;
        if (x1 !== 1'b0 || dwell_cnt !== 8'd20) begin
            mismatched++;
            $display("[TB] FAIL sensor_late_pulse: x1=%b dwell=%0d, want 0 20", x1, dwell_cnt);
        end
        v_sensor = 1'b0;
    endtask

    task automatic test_ped;
        int ticks;
        bit found;
        v_sensor = 1'b1;
        doReset();
        waitPulse(60, ticks, found);
        v_sensor = 1'b0;
        waitPulse(60, ticks, found);
        repeat (4) tick();
        compared++;
        if (dwell_cnt !== 8'd2 || vertical_light !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL ped_setup: dwell=%0d vLight=%b, want 2 11", dwell_cnt, vertical_light);
        end
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        waitPulse(60, ticks, found);
        compared++;
        if (!found || dwell_cnt !== 8'd8 || ped_ack !== 1'b1 || ticks != 6) begin
            mismatched++;
            $display("[TB] FAIL ped_ack_pulse: found=%b dwell=%0d ack=%b ticks=%0d, want 8 1 6",
                     found, dwell_cnt, ped_ack, ticks);
        end
        tick();
        compared++;
        if (ped_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ped_ack_single: ack=%b, want 0", ped_ack);
        end

        waitPulse(60, ticks, found);
        v_sensor = 1'b1;
        waitPulse(60, ticks, found);
        compared++;
        if (!found || dwell_cnt !== 8'd8 || ped_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ped_late_hpulse: found=%b dwell=%0d ack=%b, want 8 0", found, dwell_cnt, ped_ack);
        end
        ped_req = 1'b1;
        tick();
        ped_req  = 1'b0;
        v_sensor = 1'b0;
        waitPulse(60, ticks, found);
        compared++;
        if (!found || dwell_cnt !== 8'd3 || ped_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ped_late_yellow: found=%b dwell=%0d ack=%b, want 3 0", found, dwell_cnt, ped_ack);
        end
        waitPulse(60, ticks, found);
        compared++;
        if (!found || dwell_cnt !== 8'd8 || ped_ack !== 1'b1 || vertical_light !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL ped_late_vpulse: found=%b dwell=%0d ack=%b vLight=%b, want 8 1 11",
                     found, dwell_cnt, ped_ack, vertical_light);
        end
    endtask

    task automatic test_timeout;
        int ticks;
        bit found;
        bit sawLow;
        v_sensor = 1'b1;
        doReset();
        waitPulse(60, ticks, found);
        freeze = 1'b1;
        repeat (4) tick();
        compared++;
        if (fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL timeout_early: fault=%b, want 0", fault);
        end
        tick();
        compared++;
        if (fault !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL timeout_fault: fault=%b, want 1", fault);
        end
        freeze = 1'b0;
        sawLow = 1'b0;
        repeat (10) begin
            tick();
            if (x1 !== 1'b1 || fault !== 1'b1) sawLow = 1'b1;
        end
        compared++;
        if (sawLow) begin
            mismatched++;
            $display("[TB] FAIL timeout_halt: x1 left 1 or fault dropped, got=1 want=0");
        end
        v_sensor = 1'b0;
        doReset();
        compared++;
        if (fault !== 1'b0 || x1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL timeout_reset_clear: fault=%b x1=%b, want 0 1", fault, x1);
        end
    endtask

    task automatic test_bad_lights;
        doReset();
        repeat (3) tick();
        compared++;
        if (fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bad_before: fault=%b, want 0", fault);
        end
        forceEn = 1'b1;
        forceH  = 2'b01;
        forceV  = 2'b01;
        tick();
        compared++;
        if (fault !== 1'b1 || x1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bad_fault: fault=%b x1=%b, want 1 1", fault, x1);
        end
        forceEn = 1'b0;
        repeat (3) tick();
        compared++;
        if (fault !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bad_sticky: fault=%b, want 1", fault);
        end
        doReset();
        compared++;
        if (fault !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bad_reset_clear: fault=%b, want 0", fault);
        end
    endtask

    task automatic test_reset_in_pulse;
        int ticks;
        bit found;
        v_sensor = 1'b1;
        doReset();
        waitPulse(60, ticks, found);
        reset = 1'b0;
        tick();
        compared++;
        if (x1 !== 1'b1 || dwell_cnt !== 8'd0 || ped_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL pulse_reset: x1=%b dwell=%0d ack=%b, want 1 0 0", x1, dwell_cnt, ped_ack);
        end
        reset = 1'b1;
        tick();
        compared++;
        if (dwell_cnt !== 8'd0 || horizontal_light !== 2'b11 || x1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL pulse_resync: dwell=%0d hLight=%b x1=%b, want 0 11 1",
                     dwell_cnt, horizontal_light, x1);
        end
        waitPulse(60, ticks, found);
        compared++;
        if (!found || dwell_cnt !== 8'd8 || ticks != 9) begin
            mismatched++;
            $display("[TB] FAIL pulse_after_resync: found=%b dwell=%0d ticks=%0d, want 8 9",
                     found, dwell_cnt, ticks);
        end
        v_sensor = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        h_sensor   = 1'b0;
        v_sensor   = 1'b0;
        ped_req    = 1'b0;
        freeze     = 1'b0;
        forceEn    = 1'b0;
        forceH     = 2'b00;
        forceV     = 2'b00;

        test_reset();
        test_full_cycle();
        test_sensor();
        test_ped();
        test_timeout();
        test_bad_lights();
        test_reset_in_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
